// File: rtl/decode_stage_pkg.sv
// Shared decode types for the RISC-V pipeline: instruction classes, formats,
// execution units, the decoded bundle and the base opcodes.
package decode_stage_pkg;

    typedef enum logic [4:0] {
        I_NOP, I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND,
        I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW,
        I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
        I_LUI, I_JAL, I_JALR, I_FENCE, I_ECALL, I_CSRR, I_INVALID
    } instruction_type;

    typedef enum logic [2:0] {R_type, I_type, S_type, B_type, U_type, J_type} fmts;

    typedef enum logic [2:0] {
        XU_ADDER, XU_LOGICAL, XU_SHIFTER, XU_BRANCH, XU_MEMORY, XU_BYPASS
    } xu_t;

    // PC storage width inside the bundle; the stage's PC_WIDTH may not exceed it.
    localparam int DEC_PC_W = 32;

    typedef struct packed {
        instruction_type       i;
        fmts                   fmt;
        xu_t                   xu;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [31:0]           imm;
        logic [DEC_PC_W-1:0]   pc;
        logic                  pc_op;
    } decoded_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam decoded_t DECODED_RESET = '{
        i: I_NOP, fmt: I_type, xu: XU_BYPASS, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
        imm: 32'd0, pc: '0, pc_op: 1'b0
    };

    function automatic xu_t xu_of(input instruction_type t);
        case (t)
            I_ADD, I_SUB, I_SLT, I_SLTU:                       return XU_ADDER;
            I_XOR, I_OR, I_AND:                                return XU_LOGICAL;
            I_SLL, I_SRL, I_SRA:                               return XU_SHIFTER;
            I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
            I_JAL, I_JALR:                                     return XU_BRANCH;
            I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW:  return XU_MEMORY;
            default:                                           return XU_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_decoder.sv
// Purely combinational RV32I classifier: raw word to decoded bundle (pc left 0).
// Anything unrecognised becomes INVALID with I_type format and a zero immediate.
module instr_decoder
    import decode_stage_pkg::*;
(
    input  logic [31:0] in_instr,
    output decoded_t    dec_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'd0};
    assign imm_j  = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign shamt  = {27'd0, in_instr[24:20]};

    always_comb begin
        dec_o     = DECODED_RESET;
        dec_o.i   = I_INVALID;
        dec_o.rs1 = in_instr[19:15];
        dec_o.rs2 = in_instr[24:20];
        dec_o.rd  = in_instr[11:7];
        case (opcode)
            OP_REG: begin
                dec_o.fmt = R_type;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'd0: dec_o.i = I_ADD;
                        3'd1: dec_o.i = I_SLL;
                        3'd2: dec_o.i = I_SLT;
                        3'd3: dec_o.i = I_SLTU;
                        3'd4: dec_o.i = I_XOR;
                        3'd5: dec_o.i = I_SRL;
                        3'd6: dec_o.i = I_OR;
                        default: dec_o.i = I_AND;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    if (f3 == 3'd0)      dec_o.i = I_SUB;
                    else if (f3 == 3'd5) dec_o.i = I_SRA;
                end
            end
            OP_IMM: begin
                dec_o.imm = imm_i;
                case (f3)
                    3'd0: dec_o.i = (in_instr == NOP_INSTR) ? I_NOP : I_ADD;
                    3'd1: begin
                        dec_o.imm = shamt;
                        if (f7 == 7'b0000000) dec_o.i = I_SLL;
                    end
                    3'd2: dec_o.i = I_SLT;
                    3'd3: dec_o.i = I_SLTU;
                    3'd4: dec_o.i = I_XOR;
                    3'd5: begin
                        dec_o.imm = shamt;
                        if (f7 == 7'b0000000)      dec_o.i = I_SRL;
                        else if (f7 == 7'b0100000) dec_o.i = I_SRA;
                    end
                    3'd6: dec_o.i = I_OR;
                    default: dec_o.i = I_AND;
                endcase
            end
            OP_LOAD: begin
                dec_o.imm = imm_i;
                case (f3)
                    3'd0: dec_o.i = I_LB;
                    3'd1: dec_o.i = I_LH;
                    3'd2: dec_o.i = I_LW;
                    3'd4: dec_o.i = I_LBU;
                    3'd5: dec_o.i = I_LHU;
                    default: dec_o.i = I_INVALID;
                endcase
            end
            OP_STORE: begin
                dec_o.fmt = S_type;
                dec_o.imm = imm_s;
                case (f3)
                    3'd0: dec_o.i = I_SB;
                    3'd1: dec_o.i = I_SH;
                    3'd2: dec_o.i = I_SW;
                    default: dec_o.i = I_INVALID;
                endcase
            end
            OP_BRANCH: begin
                dec_o.fmt = B_type;
                dec_o.imm = imm_b;
                case (f3)
                    3'd0: dec_o.i = I_BEQ;
                    3'd1: dec_o.i = I_BNE;
                    3'd4: dec_o.i = I_BLT;
                    3'd5: dec_o.i = I_BGE;
                    3'd6: dec_o.i = I_BLTU;
                    3'd7: dec_o.i = I_BGEU;
                    default: dec_o.i = I_INVALID;
                endcase
            end
            OP_LUI: begin
                dec_o.fmt = U_type;
                dec_o.imm = imm_u;
                dec_o.i   = I_LUI;
            end
            OP_AUIPC: begin
                dec_o.fmt   = U_type;
                dec_o.imm   = imm_u;
                dec_o.i     = I_ADD;
                dec_o.pc_op = 1'b1;
            end
            OP_JAL: begin
                dec_o.fmt = J_type;
                dec_o.imm = imm_j;
                dec_o.i   = I_JAL;
            end
            OP_JALR: begin
                dec_o.imm = imm_i;
                if (f3 == 3'd0) dec_o.i = I_JALR;
            end
            OP_FENCE: begin
                dec_o.imm = imm_i;
                dec_o.i   = I_FENCE;
            end
            OP_SYSTEM: begin
                dec_o.imm = imm_i;
                dec_o.i   = (f3 == 3'd0) ? I_ECALL : I_CSRR;
            end
            default: dec_o.i = I_INVALID;
        endcase

        // Reserved encodings collapse to one canonical INVALID shape.
        if (dec_o.i == I_INVALID) begin
            dec_o.fmt   = I_type;
            dec_o.imm   = 32'd0;
            dec_o.pc_op = 1'b0;
        end
        dec_o.xu = xu_of(dec_o.i);
        if (dec_o.fmt == S_type || dec_o.fmt == B_type) begin
            dec_o.rd = 5'd0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready input, main register M driving the outputs,
// one skid register S, synchronous flush and asynchronous active-low reset.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          out_i,
    output logic [2:0]          out_fmt,
    output logic [2:0]          out_xu,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [4:0]          out_rd,
    output logic [31:0]         out_imm,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic                out_pc_op
);

    decoded_t dec_raw, dec_in;
    decoded_t m_d, m_q, s_d, s_q;
    logic     m_valid_d, m_valid_q, s_valid_d, s_valid_q;
    logic     accept, drain;

    instr_decoder u_decoder (
        .in_instr (in_instr),
        .dec_o    (dec_raw)
    );

    always_comb begin
        dec_in    = dec_raw;
        dec_in.pc = DEC_PC_W'(in_pc);
    end

    // in_ready depends only on S, so out_ready never reaches it combinationally.
    assign in_ready = !s_valid_q;
    assign accept   = in_valid && in_ready;
    assign drain    = m_valid_q && out_ready;

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || drain) begin
            if (s_valid_q) begin
                m_d       = s_q;
                m_valid_d = 1'b1;
                s_valid_d = 1'b0;
            end else begin
                m_valid_d = accept;
                if (accept) m_d = dec_in;
            end
        end else if (accept) begin
            s_d       = dec_in;
            s_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_q       <= DECODED_RESET;
            s_q       <= DECODED_RESET;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_q       <= m_d;
            s_q       <= s_d;
        end
    end

    assign out_valid = m_valid_q;
    assign out_i     = m_q.i;
    assign out_fmt   = m_q.fmt;
    assign out_xu    = m_q.xu;
    assign out_rs1   = m_q.rs1;
    assign out_rs2   = m_q.rs2;
    assign out_rd    = m_q.rd;
    assign out_imm   = m_q.imm;
    assign out_pc    = PC_WIDTH'(m_q.pc);
    assign out_pc_op = m_q.pc_op;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed decode table, backpressure/flush/reset sequences,
// and random traffic checked against a mask/match decode model and a FIFO scoreboard.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, flush, out_valid, out_ready, out_pc_op;
    logic [31:0] in_instr, in_pc, out_imm, out_pc;
    logic [4:0]  out_i, out_rs1, out_rs2, out_rd;
    logic [2:0]  out_fmt, out_xu;

    always #5 clk = ~clk;

    decode_stage #(.PC_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_i(out_i), .out_fmt(out_fmt), .out_xu(out_xu),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_pc(out_pc), .out_pc_op(out_pc_op)
    );

    typedef struct packed {
        logic [4:0]  i;
        logic [2:0]  fmt;
        logic [2:0]  xu;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        pc_op;
    } bundle_t;

    localparam int K_NONE = 0, K_I = 1, K_S = 2, K_B = 3, K_U = 4, K_J = 5, K_SH = 6;

    typedef struct {
        logic [31:0] mask, match;
        logic [4:0]  i;
        logic [2:0]  fmt, xu;
        int          immk;
        logic        pc_op;
    } rule_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        bundle_t     exp;
    } vec_t;

    rule_t   rules[$];
    vec_t    vecs[$];
    bundle_t sb[$];
    int      n_vec = 0;
    int      n_err = 0;

    task automatic add_rule(input logic [31:0] mask, input logic [31:0] match,
                            input logic [4:0] t, input logic [2:0] f, input logic [2:0] x,
                            input int k, input logic pco);
        rule_t r;
        r.mask = mask; r.match = match; r.i = t; r.fmt = f; r.xu = x;
        r.immk = k; r.pc_op = pco;
        rules.push_back(r);
    endtask

    task automatic add_vec(input string name, input logic [31:0] w, input logic [4:0] t,
                           input logic [2:0] f, input logic [2:0] x, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] imm, input logic pco);
        vec_t v;
        v.name = name; v.instr = w;
        v.exp = '{i: t, fmt: f, xu: x, rs1: rs1, rs2: rs2, rd: rd, imm: imm, pc: 32'd0, pc_op: pco};
        vecs.push_back(v);
    endtask

    // First matching mask/match rule wins; immediates built arithmetically per format.
    function automatic bundle_t model(input logic [31:0] w, input logic [31:0] pc);
        bundle_t b;
        logic signed [31:0] s;
        logic [31:0] sx20, sx31;
        bit found;
        s = w;
        sx20 = s >>> 20;
        sx31 = s >>> 31;
        b = '{i: I_INVALID, fmt: I_type, xu: XU_BYPASS, rs1: w[19:15], rs2: w[24:20],
              rd: w[11:7], imm: 32'd0, pc: pc, pc_op: 1'b0};
        found = 1'b0;
        for (int k = 0; k < rules.size(); k++) begin
            if (!found && ((w & rules[k].mask) == rules[k].match)) begin
                found = 1'b1;
                b.i = rules[k].i; b.fmt = rules[k].fmt; b.xu = rules[k].xu;
                b.pc_op = rules[k].pc_op;
                case (rules[k].immk)
                    K_I:  b.imm = sx20;
                    K_S:  b.imm = (sx20 & ~32'h1F) | ((w >> 7) & 32'h1F);
                    K_B:  b.imm = (sx31 << 12) | (((w >> 7) & 1) << 11)
                                | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1);
                    K_U:  b.imm = w & 32'hFFFF_F000;
                    K_J:  b.imm = (sx31 << 20) | (((w >> 12) & 255) << 12)
                                | (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1);
                    K_SH: b.imm = (w >> 20) & 31;
                    default: b.imm = 32'd0;
                endcase
            end
        end
        if (b.fmt == S_type || b.fmt == B_type) b.rd = 5'd0;
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        int r, k;
        r = $urandom_range(0, 9);
        k = $urandom_range(0, rules.size() - 1);
        if (r == 0) return $urandom;
        if (r == 1) return NOP_INSTR;
        if (r == 2) return ($urandom & ~32'h7F) | (rules[k].match & 32'h7F);
        return ($urandom & ~rules[k].mask) | rules[k].match;
    endfunction

    task automatic check_bundle(input string name, input bundle_t exp);
        bundle_t act;
        act = '{i: out_i, fmt: out_fmt, xu: out_xu, rs1: out_rs1, rs2: out_rs2, rd: out_rd,
                imm: out_imm, pc: out_pc, pc_op: out_pc_op};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got i=%0d fmt=%0d xu=%0d rs1=%0d rs2=%0d rd=%0d imm=%h pc=%h pc_op=%0b, expected i=%0d fmt=%0d xu=%0d rs1=%0d rs2=%0d rd=%0d imm=%h pc=%h pc_op=%0b",
                     name, act.i, act.fmt, act.xu, act.rs1, act.rs2, act.rd, act.imm, act.pc,
                     act.pc_op, exp.i, exp.fmt, exp.xu, exp.rs1, exp.rs2, exp.rd, exp.imm,
                     exp.pc, exp.pc_op);
        end else begin
            $display("ok   %s: i=%0d fmt=%0d xu=%0d rd=%0d imm=%h pc=%h", name, act.i, act.fmt,
                     act.xu, act.rd, act.imm, act.pc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        bundle_t ea, eb, ec, rst_b;
        logic will_acc, will_drain;

        reset = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
        flush = 1'b0; out_ready = 1'b0;

        add_rule(32'hFFFFFFFF, 32'h00000013, I_NOP,  I_type, XU_BYPASS,  K_I,    1'b0);
        add_rule(32'hFE00707F, 32'h00000033, I_ADD,  R_type, XU_ADDER,   K_NONE, 1'b0);
        add_rule(32'hFE00707F, 32'h40000033, I_SUB,  R_type, XU_ADDER,   K_NONE, 1'b0);
        add_rule(32'hFE00707F, 32'h00001033, I_SLL,  R_type, XU_SHIFTER, K_NONE, 1'b0);
        add_rule(32'hFE00707F, 32'h00002033, I_SLT,  R_type, XU_ADDER,   K_NONE, 1'b0);
        add_rule(32'hFE00707F, 32'h00003033, I_SLTU, R_type, XU_ADDER,   K_NONE, 1'b0);
        add_rule(32'hFE00707F, 32'h00004033, I_XOR,  R_type, XU_LOGICAL, K_NONE, 1'b0);
        add_rule(32'hFE00707F, 32'h00005033, I_SRL,  R_type, XU_SHIFTER, K_NONE, 1'b0);
        add_rule(32'hFE00707F, 32'h40005033, I_SRA,  R_type, XU_SHIFTER, K_NONE, 1'b0);
        add_rule(32'hFE00707F, 32'h00006033, I_OR,   R_type, XU_LOGICAL, K_NONE, 1'b0);
        add_rule(32'hFE00707F, 32'h00007033, I_AND,  R_type, XU_LOGICAL, K_NONE, 1'b0);
        add_rule(32'h0000707F, 32'h00000013, I_ADD,  I_type, XU_ADDER,   K_I,    1'b0);
        add_rule(32'h0000707F, 32'h00002013, I_SLT,  I_type, XU_ADDER,   K_I,    1'b0);
        add_rule(32'h0000707F, 32'h00003013, I_SLTU, I_type, XU_ADDER,   K_I,    1'b0);
        add_rule(32'h0000707F, 32'h00004013, I_XOR,  I_type, XU_LOGICAL, K_I,    1'b0);
        add_rule(32'h0000707F, 32'h00006013, I_OR,   I_type, XU_LOGICAL, K_I,    1'b0);
        add_rule(32'h0000707F, 32'h00007013, I_AND,  I_type, XU_LOGICAL, K_I,    1'b0);
        add_rule(32'hFE00707F, 32'h00001013, I_SLL,  I_type, XU_SHIFTER, K_SH,   1'b0);
        add_rule(32'hFE00707F, 32'h00005013, I_SRL,  I_type, XU_SHIFTER, K_SH,   1'b0);
        add_rule(32'hFE00707F, 32'h40005013, I_SRA,  I_type, XU_SHIFTER, K_SH,   1'b0);
        add_rule(32'h0000707F, 32'h00000003, I_LB,   I_type, XU_MEMORY,  K_I,    1'b0);
        add_rule(32'h0000707F, 32'h00001003, I_LH,   I_type, XU_MEMORY,  K_I,    1'b0);
        add_rule(32'h0000707F, 32'h00002003, I_LW,   I_type, XU_MEMORY,  K_I,    1'b0);
        add_rule(32'h0000707F, 32'h00004003, I_LBU,  I_type, XU_MEMORY,  K_I,    1'b0);
        add_rule(32'h0000707F, 32'h00005003, I_LHU,  I_type, XU_MEMORY,  K_I,    1'b0);
        add_rule(32'h0000707F, 32'h00000023, I_SB,   S_type, XU_MEMORY,  K_S,    1'b0);
        add_rule(32'h0000707F, 32'h00001023, I_SH,   S_type, XU_MEMORY,  K_S,    1'b0);
        add_rule(32'h0000707F, 32'h00002023, I_SW,   S_type, XU_MEMORY,  K_S,    1'b0);
        add_rule(32'h0000707F, 32'h00000063, I_BEQ,  B_type, XU_BRANCH,  K_B,    1'b0);
        add_rule(32'h0000707F, 32'h00001063, I_BNE,  B_type, XU_BRANCH,  K_B,    1'b0);
        add_rule(32'h0000707F, 32'h00004063, I_BLT,  B_type, XU_BRANCH,  K_B,    1'b0);
        add_rule(32'h0000707F, 32'h00005063, I_BGE,  B_type, XU_BRANCH,  K_B,    1'b0);
        add_rule(32'h0000707F, 32'h00006063, I_BLTU, B_type, XU_BRANCH,  K_B,    1'b0);
        add_rule(32'h0000707F, 32'h00007063, I_BGEU, B_type, XU_BRANCH,  K_B,    1'b0);
        add_rule(32'h0000007F, 32'h00000037, I_LUI,  U_type, XU_BYPASS,  K_U,    1'b0);
        add_rule(32'h0000007F, 32'h00000017, I_ADD,  U_type, XU_ADDER,   K_U,    1'b1);
        add_rule(32'h0000007F, 32'h0000006F, I_JAL,  J_type, XU_BRANCH,  K_J,    1'b0);
        add_rule(32'h0000707F, 32'h00000067, I_JALR, I_type, XU_BRANCH,  K_I,    1'b0);
        add_rule(32'h0000007F, 32'h0000000F, I_FENCE, I_type, XU_BYPASS, K_I,    1'b0);
        add_rule(32'h0000707F, 32'h00000073, I_ECALL, I_type, XU_BYPASS, K_I,    1'b0);
        add_rule(32'h0000007F, 32'h00000073, I_CSRR, I_type, XU_BYPASS,  K_I,    1'b0);

        add_vec("addi",  32'h00500093, I_ADD,   I_type, XU_ADDER,   0, 5, 1, 32'd5, 1'b0);
        add_vec("beq",   32'hFE208EE3, I_BEQ,   B_type, XU_BRANCH,  1, 2, 0, 32'hFFFFFFFC, 1'b0);
        add_vec("sw",    32'h00512423, I_SW,    S_type, XU_MEMORY,  2, 5, 0, 32'd8, 1'b0);
        add_vec("sra",   32'h4020D1B3, I_SRA,   R_type, XU_SHIFTER, 1, 2, 3, 32'd0, 1'b0);
        add_vec("inval", 32'hFFFFFFFF, I_INVALID, I_type, XU_BYPASS, 31, 31, 31, 32'd0, 1'b0);
        add_vec("lui",   32'h123452B7, I_LUI,   U_type, XU_BYPASS,  8, 3, 5, 32'h12345000, 1'b0);
        add_vec("auipc", 32'h00001517, I_ADD,   U_type, XU_ADDER,   0, 0, 10, 32'h00001000, 1'b1);
        add_vec("jal",   32'h008000EF, I_JAL,   J_type, XU_BRANCH,  0, 8, 1, 32'd8, 1'b0);
        add_vec("srai",  32'h4030D093, I_SRA,   I_type, XU_SHIFTER, 1, 3, 1, 32'd3, 1'b0);
        add_vec("nop",   32'h00000013, I_NOP,   I_type, XU_BYPASS,  0, 0, 0, 32'd0, 1'b0);
        add_vec("ecall", 32'h00000073, I_ECALL, I_type, XU_BYPASS,  0, 0, 0, 32'd0, 1'b0);

        // Reset state
        tick();
        tick();
        rst_b = '{i: I_NOP, fmt: I_type, xu: XU_BYPASS, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
                  imm: 32'd0, pc: 32'd0, pc_op: 1'b0};
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_in_ready", in_ready, 1'b1);
        check_bundle("reset_bundle", rst_b);
        reset = 1'b1;
        tick();

        // Directed decode table, one accept then drain per entry
        out_ready = 1'b1;
        for (int k = 0; k < vecs.size(); k++) begin
            bundle_t e;
            in_valid = 1'b1;
            in_instr = vecs[k].instr;
            in_pc    = 32'h1000 + 32'(k * 4);
            tick();
            in_valid = 1'b0;
            e = vecs[k].exp;
            e.pc = in_pc;
            check_bit({vecs[k].name, "_latency"}, out_valid, 1'b1);
            check_bundle(vecs[k].name, e);
            tick();
        end
        check_bit("table_drained", out_valid, 1'b0);

        // Backpressure: A, B, C back to back with out_ready low
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00A00113; in_pc = 32'h2000;
        ea = model(in_instr, in_pc);
        tick();
        check_bit("abc_inready_after_a", in_ready, 1'b1);
        check_bundle("abc_a_in_m", ea);
        in_instr = 32'h00B18193; in_pc = 32'h2004;
        eb = model(in_instr, in_pc);
        tick();
        check_bit("abc_inready_after_b", in_ready, 1'b0);
        check_bundle("abc_hold_a_1", ea);
        in_instr = 32'h00C20213; in_pc = 32'h2008;
        ec = model(in_instr, in_pc);
        tick();
        check_bit("abc_c_refused", in_ready, 1'b0);
        check_bundle("abc_hold_a_2", ea);
        out_ready = 1'b1;
        tick();
        check_bit("abc_inready_back", in_ready, 1'b1);
        check_bundle("abc_b_out", eb);
        tick();
        in_valid = 1'b0;
        check_bundle("abc_c_out", ec);
        tick();
        check_bit("abc_empty", out_valid, 1'b0);

        // Flush with M and S full and a new instruction offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h3000;
        tick();
        in_instr = 32'h00200113; in_pc = 32'h3004;
        tick();
        check_bit("flush_full_inready", in_ready, 1'b0);
        in_instr = 32'h00300193; in_pc = 32'h3008; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check_bit("flush_out_valid", out_valid, 1'b0);
        check_bit("flush_in_ready", in_ready, 1'b1);
        tick();
        check_bit("flush_no_ghost_1", out_valid, 1'b0);
        tick();
        check_bit("flush_no_ghost_2", out_valid, 1'b0);

        // Flush coinciding with an accept into an empty stage
        in_valid = 1'b1; in_instr = 32'h00400213; in_pc = 32'h300C; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_bit("flush_accept_dropped", out_valid, 1'b0);

        // Reset between clock edges while M holds an instruction
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00700393; in_pc = 32'h4000;
        tick();
        in_valid = 1'b0;
        check_bit("rstmid_loaded", out_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_bit("rstmid_async_valid", out_valid, 1'b0);
        check_bit("rstmid_async_nop", out_i == I_NOP, 1'b1);
        check_bit("rstmid_in_ready", in_ready, 1'b1);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h4004;
        ea = model(in_instr, in_pc);
        tick();
        in_valid = 1'b0;
        check_bundle("rstmid_first_after", ea);
        tick();

        // Random traffic against the scoreboard
        sb.delete();
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            check_bit("rnd_out_valid", out_valid, sb.size() > 0);
            check_bit("rnd_in_ready", in_ready, sb.size() < 2);
            if (out_valid && sb.size() > 0) check_bundle("rnd_out", sb[0]);
            will_acc   = in_valid && (sb.size() < 2);
            will_drain = out_ready && (sb.size() > 0);
            ea = model(in_instr, in_pc);
            tick();
            if (flush) begin
                sb.delete();
            end else begin
                if (will_drain) void'(sb.pop_front());
                if (will_acc) sb.push_back(ea);
            end
        end
        flush = 1'b0; in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
